// File: rtl/id_stage_pkg.sv
// Shared decode constants for the decode stage: LoongArch branch opcodes,
// instruction field positions and the store detector used for read-port selection.
package id_stage_pkg;

  localparam logic [5:0] OP_JIRL = 6'b010011;
  localparam logic [5:0] OP_B    = 6'b010100;
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BNE  = 6'b010111;
  localparam logic [5:0] OP_BLT  = 6'b011000;
  localparam logic [5:0] OP_BGE  = 6'b011001;
  localparam logic [5:0] OP_BLTU = 6'b011010;
  localparam logic [5:0] OP_BGEU = 6'b011011;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RJ_MSB  = 9;
  localparam int RJ_LSB  = 5;
  localparam int RD_MSB  = 4;
  localparam int RD_LSB  = 0;
  localparam int RK_MSB  = 14;
  localparam int RK_LSB  = 10;

  localparam logic [9:0] OP10_ST_B = 10'b0010100100;
  localparam logic [9:0] OP10_ST_H = 10'b0010100101;
  localparam logic [9:0] OP10_ST_W = 10'b0010100110;

  localparam logic [4:0] BL_LINK_REG = 5'd1;

  // Stores read their data register through the rd field, like branches.
  function automatic logic is_store(input logic [31:0] inst);
    return (inst[31:22] == OP10_ST_B) || (inst[31:22] == OP10_ST_H) ||
           (inst[31:22] == OP10_ST_W);
  endfunction

endpackage

// File: rtl/id_stage_branch_unit.sv
// Combinational branch resolution: decodes the opcode, evaluates the condition
// and forms the redirect target, link flag and writeback register.
module id_stage_branch_unit
  import id_stage_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        is_br_o,
  output logic        taken_o,
  output logic [31:0] target_o,
  output logic        link_o,
  output logic [4:0]  waddr_o
);

  logic [31:0] off16;
  logic [31:0] off26;
  logic        eq;
  logic        lt_s;
  logic        lt_u;

  // Kept apart from the condition logic: it feeds the rd/rk read-port select.
  assign is_br_o = (opcode_i >= OP_JIRL) && (opcode_i <= OP_BGEU);

  assign off16 = {{14{inst_i[25]}}, inst_i[25:10], 2'b00};
  assign off26 = {{4{inst_i[9]}}, inst_i[9:0], inst_i[25:10], 2'b00};
  assign eq    = (src1_i == src2_i);
  assign lt_s  = ($signed(src1_i) < $signed(src2_i));
  assign lt_u  = (src1_i < src2_i);

  always_comb begin
    taken_o  = 1'b0;
    link_o   = 1'b0;
    waddr_o  = inst_i[RD_MSB:RD_LSB];
    target_o = pc_i + off16;
    case (opcode_i)
      OP_B: begin
        taken_o  = 1'b1;
        target_o = pc_i + off26;
      end
      OP_BL: begin
        taken_o  = 1'b1;
        link_o   = 1'b1;
        waddr_o  = BL_LINK_REG;
        target_o = pc_i + off26;
      end
      OP_JIRL: begin
        taken_o  = 1'b1;
        link_o   = 1'b1;
        target_o = src1_i + off16;
      end
      OP_BEQ:  taken_o = eq;
      OP_BNE:  taken_o = ~eq;
      OP_BLT:  taken_o = lt_s;
      OP_BGE:  taken_o = ~lt_s;
      OP_BLTU: taken_o = lt_u;
      OP_BGEU: taken_o = ~lt_u;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: one-entry {pc, inst} register between fetch and EXE handshakes,
// register-file read and branch resolution with a same-cycle redirect to fetch.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int BUS_W = 64,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_bus,
  input  logic             flush_in,
  input  logic             rf_hazard,
  output logic [RF_AW-1:0] rf_raddr1,
  output logic [RF_AW-1:0] rf_raddr2,
  input  logic [31:0]      rf_rdata1,
  input  logic [31:0]      rf_rdata2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_src1,
  output logic [31:0]      out_src2,
  output logic             out_link,
  output logic [RF_AW-1:0] out_waddr,
  output logic             is_branch,
  output logic             flush,
  output logic [31:0]      dnpc
);

  logic             valid_q, valid_d;
  logic [BUS_W-1:0] bus_q, bus_d;
  logic [31:0]      pc, inst;
  logic             out_fire;
  logic             br_is_br, br_taken, br_link;
  logic [31:0]      br_target;
  logic [4:0]       br_waddr;
  logic [4:0]       raddr2_sel;

  assign pc   = bus_q[BUS_W-1 -: 32];
  assign inst = bus_q[31:0];

  assign raddr2_sel = (br_is_br || is_store(inst)) ? inst[RD_MSB:RD_LSB]
                                                   : inst[RK_MSB:RK_LSB];
  assign rf_raddr1  = RF_AW'(inst[RJ_MSB:RJ_LSB]);
  assign rf_raddr2  = RF_AW'(raddr2_sel);

  id_stage_branch_unit u_branch (
    .opcode_i (inst[OPC_MSB:OPC_LSB]),
    .pc_i     (pc),
    .inst_i   (inst),
    .src1_i   (rf_rdata1),
    .src2_i   (rf_rdata2),
    .is_br_o  (br_is_br),
    .taken_o  (br_taken),
    .target_o (br_target),
    .link_o   (br_link),
    .waddr_o  (br_waddr)
  );

  assign out_valid = valid_q & ~rf_hazard & ~flush_in;
  assign out_fire  = out_valid & out_ready;
  assign is_branch = out_fire & br_taken;
  assign flush     = is_branch;
  assign dnpc      = is_branch ? br_target : 32'd0;
  // A redirect refuses the wrong-path instruction fetch offers in the same cycle.
  assign in_ready  = (~valid_q | out_fire) & ~is_branch & ~flush_in;

  assign out_pc    = pc;
  assign out_inst  = inst;
  assign out_src1  = rf_rdata1;
  assign out_src2  = rf_rdata2;
  assign out_link  = br_link;
  assign out_waddr = RF_AW'(br_waddr);

  always_comb begin
    valid_d = valid_q;
    bus_d   = bus_q;
    if (flush_in) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      bus_d   = in_bus;
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      bus_q   <= '0;
    end else begin
      valid_q <= valid_d;
      bus_q   <= bus_d;
    end
  end

endmodule
